// File: rtl/line_buffer_11_rows.sv
// Eleven-row line buffer: ten circular line memories plus the live pixel form one column of an 11-row stack per beat.
// Optional build macro LINE_BUFFER_11_TOP_PAD_EN: emit from row 0, with rows above the image padded as zero.
module line_buffer_11_rows #(
    parameter int unsigned COLS = 11,
    parameter int unsigned ROWS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_i,
    input  logic [7:0] data_i,
    output logic [7:0] S1_o,
    output logic [7:0] S2_o,
    output logic [7:0] S3_o,
    output logic [7:0] S4_o,
    output logic [7:0] S5_o,
    output logic [7:0] S6_o,
    output logic [7:0] S7_o,
    output logic [7:0] S8_o,
    output logic [7:0] S9_o,
    output logic [7:0] S10_o,
    output logic [7:0] S11_o,
    output logic       done_o,
    output logic       progress_done_o
);

    localparam int unsigned DW    = 8;
    localparam int unsigned NMEM  = 10;
    localparam int unsigned NTAP  = NMEM + 1;
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);

`ifdef LINE_BUFFER_11_TOP_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [DW-1:0]      tap_q [NTAP];
    logic [DW-1:0]      tap_d [NTAP];
    logic               done_q, done_d;
    logic               prog_q, prog_d;

    logic [DW-1:0]      mem_q [NMEM][COLS];
    logic [DW-1:0]      rd    [NMEM];

    logic               accept;
    logic               col_wrap;
    logic               last_pix;

    assign accept   = done_i;
    assign col_wrap = (col_q == COL_W'(COLS - 1));
    assign last_pix = col_wrap && (row_q == ROW_W'(ROWS - 1));

    // Memory k-1 holds row r-k at every column; one shared pointer makes the update a row shift.
    always_comb begin
        for (int unsigned k = 0; k < NMEM; k++) begin
            rd[k] = mem_q[k][col_q];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[0][col_q] <= data_i;
            for (int unsigned k = 1; k < NMEM; k++) begin
                mem_q[k][col_q] <= mem_q[k-1][col_q];
            end
        end
    end

    // Next-state, counter and tap logic.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        prog_d  = 1'b0;
        for (int unsigned k = 0; k < NTAP; k++) begin
            tap_d[k] = tap_q[k];
        end

        if (accept) begin
            tap_d[NTAP-1] = data_i;
            // Rows that do not yet exist in this frame read as zero, hiding stale memory.
            for (int unsigned k = 1; k <= NMEM; k++) begin
                tap_d[NTAP-1-k] = (row_q >= ROW_W'(k)) ? rd[k-1] : '0;
            end
            done_d = PAD_EN || (row_q >= ROW_W'(NMEM));

            if (last_pix) begin
                col_d   = '0;
                row_d   = '0;
                prog_d  = 1'b1;
                state_d = DONE;
            end else begin
                col_d = col_wrap ? '0 : col_q + COL_W'(1);
                if (col_wrap && (row_q != ROW_W'(ROWS - 1))) begin
                    row_d = row_q + ROW_W'(1);
                end
                state_d = (PAD_EN || (row_d >= ROW_W'(NMEM))) ? STREAM : FILL;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            prog_q  <= 1'b0;
            for (int unsigned k = 0; k < NTAP; k++) begin
                tap_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
            prog_q  <= prog_d;
            for (int unsigned k = 0; k < NTAP; k++) begin
                tap_q[k] <= tap_d[k];
            end
        end
    end

    assign S1_o            = tap_q[0];
    assign S2_o            = tap_q[1];
    assign S3_o            = tap_q[2];
    assign S4_o            = tap_q[3];
    assign S5_o            = tap_q[4];
    assign S6_o            = tap_q[5];
    assign S7_o            = tap_q[6];
    assign S8_o            = tap_q[7];
    assign S9_o            = tap_q[8];
    assign S10_o           = tap_q[9];
    assign S11_o           = tap_q[10];
    assign done_o          = done_q;
    assign progress_done_o = prog_q;

endmodule

// File: tb/tb_line_buffer_11_rows.sv
// Scoreboard bench for line_buffer_11_rows: a frame-image model predicts each beat's 11-row column.
// Honours LINE_BUFFER_11_TOP_PAD_EN the same way as the design.
module tb_line_buffer_11_rows;

    localparam int COLS = 11;
    localparam int ROWS = 11;
`ifdef LINE_BUFFER_11_TOP_PAD_EN
    localparam bit PAD       = 1'b1;
    localparam int EXP_BEATS = ROWS * COLS;
`else
    localparam bit PAD       = 1'b0;
    localparam int EXP_BEATS = (ROWS - 10) * COLS;
`endif

    typedef struct packed {
        logic [10:0][7:0] taps;
        logic             prog;
        logic [31:0]      cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       done_i;
    logic [7:0] data_i;
    logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11;
    logic       done_o, prog_o;
    logic [10:0][7:0] taps;

    assign taps = {s11, s10, s9, s8, s7, s6, s5, s4, s3, s2, s1};

    line_buffer_11_rows #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i),
        .S1_o(s1), .S2_o(s2), .S3_o(s3), .S4_o(s4), .S5_o(s5), .S6_o(s6),
        .S7_o(s7), .S8_o(s8), .S9_o(s9), .S10_o(s10), .S11_o(s11),
        .done_o(done_o), .progress_done_o(prog_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   beats = 0;
    int   progs = 0;
    exp_t q[$];

    logic [7:0] img [ROWS][COLS];
    int pr = 0;
    int pc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done_o beat is popped and compared against the model's prediction.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            checks++;
            if (taps != '0 || done_o || prog_o) begin
                failures++;
                $display("FAIL reset_outputs: taps=%h done=%b prog=%b required all zero", taps, done_o, prog_o);
            end
        end else if (done_o) begin
            beats++;
            if (prog_o) progs++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: cyc=%0d taps=%h required no beat", cyc, taps);
            end else begin
                e = q.pop_front();
                if (e.cyc != 32'(cyc)) begin
                    failures++;
                    $display("FAIL beat_timing: got cycle %0d required %0d", cyc, e.cyc);
                end
                checks++;
                if (taps != e.taps || prog_o != e.prog) begin
                    failures++;
                    $display("FAIL beat_data: cyc=%0d taps=%h prog=%b required taps=%h prog=%b",
                             cyc, taps, prog_o, e.taps, e.prog);
                end
            end
        end else begin
            if (q.size() != 0 && q[0].cyc <= 32'(cyc)) begin
                checks++;
                failures++;
                e = q.pop_front();
                $display("FAIL missing_beat: no done_o at cycle %0d required taps=%h", cyc, e.taps);
            end
            if (prog_o) begin
                checks++;
                failures++;
                $display("FAIL prog_without_done: progress_done_o=1 with done_o=0 at cycle %0d", cyc);
            end
        end
    end

    // One stimulus cycle; accepted pixels update the frame image and queue their expected beat.
    task automatic drive(input logic v, input logic [7:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        done_i = v;
        data_i = d;
        if (v) begin
            img[pr][pc] = d;
            if (PAD || pr >= 10) begin
                e.taps[10] = d;
                for (int k = 1; k <= 10; k++) begin
                    e.taps[10-k] = (pr >= k) ? img[pr-k][pc] : 8'h00;
                end
                e.prog = (pr == ROWS - 1) && (pc == COLS - 1);
                e.cyc  = 32'(cyc + 1);
                q.push_back(e);
            end
            if (pc == COLS - 1) begin
                pc = 0;
                pr = (pr == ROWS - 1) ? 0 : pr + 1;
            end else begin
                pc++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
    endtask

    // gap: 0 none, 1 alternate, 2 random. rnd selects random pixel data instead of row*11+col+base.
    task automatic send_frame(input bit rnd, input int base, input int gap);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (gap == 1 && (r + c) > 0) idle(1);
                if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                drive(1'b1, rnd ? 8'($urandom) : 8'(r * 11 + c + base));
            end
        end
    endtask

    task automatic check_counts(input string name, input int frames);
        idle(3);
        checks++;
        if (beats != frames * EXP_BEATS || progs != frames || q.size() != 0) begin
            failures++;
            $display("FAIL %s_counts: beats=%0d progs=%0d pending=%0d required beats=%0d progs=%0d pending=0",
                     name, beats, progs, q.size(), frames * EXP_BEATS, frames);
        end
        beats = 0;
        progs = 0;
    endtask

    initial begin
        rst    = 1'b1;
        done_i = 1'b1;
        data_i = 8'h5a;
        repeat (4) @(posedge clk);
        #1;
        done_i = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        checks++;
        if (taps != '0 || done_o || prog_o) begin
            failures++;
            $display("FAIL post_reset_idle: taps=%h done=%b prog=%b required zero", taps, done_o, prog_o);
        end

        send_frame(1'b0, 0, 0);
        check_counts("continuous", 1);

        send_frame(1'b0, 0, 1);
        check_counts("gapped", 1);

        send_frame(1'b0, 0, 0);
        send_frame(1'b0, 128, 0);
        check_counts("back_to_back", 2);

        for (int i = 0; i < 60; i++) drive(1'b1, 8'($urandom));
        idle(2);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        done_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        done_i = 1'b0;
        rst    = 1'b0;
        pr = 0;
        pc = 0;
        q.delete();
        beats = 0;
        progs = 0;
        send_frame(1'b1, 0, 2);
        check_counts("after_mid_reset", 1);

        for (int f = 0; f < 3; f++) send_frame(1'b1, 0, 2);
        check_counts("random_frames", 3);

        send_frame(1'b1, 0, 0);
        send_frame(1'b1, 0, 1);
        check_counts("random_b2b", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_buffer_11_rows.md
Name: line_buffer_11_rows

Overview:
- Upstream feeder for the 11x11 window buffer.
- Accepts one raster-order 8-bit pixel stream, COLS wide and ROWS tall.
- Emits 11 vertically aligned row taps (S1_o..S11_o) plus a qualifying done_o, so every done_o beat gives one column of an 11-row stack.
- Sits between the pixel source and the window buffer's S1_i..S11_i / done_i inputs.

Parameters:
- COLS, 11, pixels per image row; line memory depth; >= 2.
- ROWS, 11, rows per frame; >= 11.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- done_i  input  1  pixel valid strobe; data_i is accepted on each cycle where it is 1.
- data_i  input  8  incoming pixel, raster order.
- S1_o..S11_o  output  8 each  row taps, registered; S1_o = oldest row (r-10), S11_o = current row r, same column.
- done_o  output  1  taps valid this cycle.
- progress_done_o  output  1  one-cycle pulse: the frame's last pixel has been emitted.

Behaviour:
- Reset (async, rst=1): all S*_o=0, done_o=0, progress_done_o=0, col_cnt=0, row_cnt=0, FSM=IDLE. Line memory contents are not reset; they are never visible unmasked (see masking).
- Storage:
  - 10 circular line memories (rows r-1..r-10), each COLS x 8, sharing one column pointer col_cnt.
  - On an accepted pixel at column c, memory k is read at c and written with memory k-1's old value at c. Memory 1 is written with data_i. This is a row shift.
- Counters:
  - col_cnt advances on each accepted pixel and wraps COLS-1 -> 0.
  - row_cnt increments on the column wrap; it saturates at ROWS-1 until frame end.
  - Widths: $clog2 of the respective parameter.
- FSM states and transitions:
  - IDLE: first done_i -> FILL (or STREAM when row_cnt >= 10, for the ROWS=11 edge case: no FILL if row 0..9 already complete).
  - FILL: rows 0..9; pixels are stored, done_o stays 0. Leaving the last pixel of row 9 -> STREAM.
  - STREAM: rows 10..ROWS-1.
  - Accepting pixel (ROWS-1, COLS-1) -> DONE.
  - DONE: lasts one cycle; progress_done_o=1 this cycle only; counters are cleared; -> IDLE.
- Latency: 1 cycle. A pixel accepted at cycle t appears on S11_o at t+1, with the same-column pixels of the previous 10 rows on S10_o..S1_o. done_o=1 at t+1 iff the pixel's row >= 10.
- Gaps: done_i=0 freezes counters and memories. done_o=0 on the following cycle; S*_o hold their last values.
- progress_done_o is asserted in the same cycle as the final done_o.
- done_i in the DONE cycle is accepted as pixel (0,0) of the next frame. Counters are cleared to 0, then advanced to col=1. FSM -> FILL.
- Reset mid-frame: output and counter state is discarded immediately; the next done_i starts a new frame at (0,0).
- Masking: tap k (S(11-k)_o, k = 1..10 rows back) is forced to 0 whenever row_cnt < k. Stale memory data is never output.

Optional Feature:
- Macro: LINE_BUFFER_11_TOP_PAD_EN.
- Defined: FILL state is skipped. done_o=1 for every accepted pixel from row 0. Rows above the image are zero via the masking rule. The frame yields ROWS*COLS done_o beats. progress_done_o timing is unchanged.
- Undefined: behaviour as above; the frame yields (ROWS-10)*COLS done_o beats.

Test Plan:
- Reset check: with rst high, all outputs 0. Drive done_i=1 during reset -> no state change. Release -> IDLE.
- Default frame, continuous stream: COLS=ROWS=11, done_i=1 for 121 cycles, data=row*11+col. Required: exactly 11 done_o beats, on cycles 111..121 after the first accept. On beat c: S1_o=c, S11_o=110+c. progress_done_o=1 only on the last beat.
- Gapped input: same frame with done_i toggling 1/0. Required: identical tap values and beat count. done_o never asserted in a cycle following done_i=0.
- Back-to-back frames: two 121-pixel frames with no idle cycle between them (second data offset +128). Required: second frame produces 11 beats, S11_o=238+c. No frame-1 data leaks: any value <128 in frame 2 is an error.
- Reset mid-frame: assert rst at pixel 60, then send a full frame. Required: outputs 0 during reset; the new frame is output correctly from (0,0).
- LINE_BUFFER_11_TOP_PAD_EN build: default frame -> 121 done_o beats. First beat: S11_o=0, S1_o..S10_o=0. Beat for pixel (3,2): S8_o=2, S9_o=13, S10_o=24, S11_o=35, S1_o..S7_o=0.
